// File: rtl/proc_run_ctrl.sv
// Purpose : bring-up run controller for processor_arm: sequences core reset, bounds the run,
//           detects end of program (halt or timeout), pulses dump and gathers DM write stats.
// Latency : every output is registered and changes one cycle after the condition that causes it.
//           There is no backpressure: the inputs are snooped every cycle, and start is a one-shot
//           that is only honoured in DONE.
//
// Ports
//   CLOCK_50        system clock, rising edge
//   reset           asynchronous active-low reset
//   start           single-cycle rerun request (used only in DONE)
//   pc              core program counter (snooped)
//   DM_writeEnable  core data-memory write strobe (snooped)
//   DM_addr         core data-memory address (snooped)
//   DM_writeData    core data-memory write data (snooped)
//   proc_reset      active-high reset to the core
//   dump            memory-dump request to the core
//   done            run finished
//   halted          1 = run ended by halt, 0 = ended by timeout (valid with done)
//   cycle_count     RUN cycles elapsed, saturating
//   wr_count        DM writes seen in RUN, saturating
//   watch_hit       sticky flag: a RUN write hit WATCH_ADDR
//   watch_data      data of the most recent RUN write to WATCH_ADDR
module proc_run_ctrl #(
   parameter int             N            = 64,
   parameter int             RESET_CYCLES = 2,
   parameter int             MAX_CYCLES   = 130,
   parameter int             HALT_WINDOW  = 4,
   parameter int             DUMP_CYCLES  = 2,
   parameter logic [N-1:0]   WATCH_ADDR   = 'h8
) (
   input  logic         CLOCK_50,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] pc,
   input  logic         DM_writeEnable,
   input  logic [N-1:0] DM_addr,
   input  logic [N-1:0] DM_writeData,
   output logic         proc_reset,
   output logic         dump,
   output logic         done,
   output logic         halted,
   output logic [31:0]  cycle_count,
   output logic [15:0]  wr_count,
   output logic         watch_hit,
   output logic [N-1:0] watch_data
);

   // A counter width of at least 1 bit is kept even when the phase length is 1.
   localparam int HCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int DCW = (DUMP_CYCLES  > 1) ? $clog2(DUMP_CYCLES)  : 1;
   localparam int SCW = $clog2(HALT_WINDOW + 1);

   localparam logic [HCW-1:0] HOLD_LAST = HCW'(RESET_CYCLES - 1);
   localparam logic [DCW-1:0] DUMP_LAST = DCW'(DUMP_CYCLES - 1);
   localparam logic [SCW-1:0] SAME_LAST = SCW'(HALT_WINDOW - 1);
   localparam logic [31:0]    CYC_LAST  = 32'(MAX_CYCLES - 1);

   typedef enum logic [1:0] {
      S_HOLD = 2'd0,
      S_RUN  = 2'd1,
      S_DUMP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t         state;
   state_t         state_nxt;

   logic [HCW-1:0] hold_cnt;
   logic [DCW-1:0] dump_cnt;
   logic [SCW-1:0] same_cnt;
   logic [N-1:0]   pc_q;
   logic           pc_valid;

   logic           hold_last;
   logic           dump_last;
   logic           pc_same;
   logic           halt_det;
   logic           timeout_det;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state <= S_HOLD;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_nxt   = state;
      hold_last   = (hold_cnt == HOLD_LAST);
      dump_last   = (dump_cnt == DUMP_LAST);
      pc_same     = pc_valid && (pc == pc_q);
      halt_det    = pc_same && (same_cnt == SAME_LAST);
      timeout_det = (cycle_count == CYC_LAST);

      case (state)
         S_HOLD:  if (hold_last)               state_nxt = S_RUN;
         S_RUN:   if (halt_det || timeout_det) state_nxt = S_DUMP;
         S_DUMP:  if (dump_last)               state_nxt = S_DONE;
         S_DONE:  if (start)                   state_nxt = S_HOLD;
         default:                              state_nxt = S_HOLD;
      endcase
   end

   // ---------------------------------------------------------------- datapath and outputs
   // The outputs are decoded from state_nxt, so each one is registered yet already matches
   // the state it describes in the first cycle of that state.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         proc_reset  <= 1'b1;
         dump        <= 1'b0;
         done        <= 1'b0;
         halted      <= 1'b0;
         cycle_count <= '0;
         wr_count    <= '0;
         watch_hit   <= 1'b0;
         watch_data  <= '0;
         hold_cnt    <= '0;
         dump_cnt    <= '0;
         same_cnt    <= '0;
         pc_q        <= '0;
         pc_valid    <= 1'b0;
      end else begin
         // In DONE the core is held in reset. In DUMP it is released so that it can
         // keep clocking while the dump takes place.
         proc_reset <= (state_nxt == S_HOLD) || (state_nxt == S_DONE);
         dump       <= (state_nxt == S_DUMP);
         done       <= (state_nxt == S_DONE);

         case (state)
            S_HOLD: begin
               hold_cnt <= hold_last ? '0 : hold_cnt + HCW'(1);
            end

            S_RUN: begin
               if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
               pc_q     <= pc;
               pc_valid <= 1'b1;
               same_cnt <= pc_same ? same_cnt + SCW'(1) : '0;
               dump_cnt <= '0;
               // If both detectors fire in the same cycle, the halt wins.
               if (halt_det || timeout_det) halted <= halt_det;

               if (DM_writeEnable) begin
                  if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
                  if (DM_addr == WATCH_ADDR) begin
                     watch_hit  <= 1'b1;
                     watch_data <= DM_writeData;
                  end
               end
            end

            S_DUMP: begin
               dump_cnt <= dump_cnt + DCW'(1);
            end

            S_DONE: begin
               if (start) begin
                  cycle_count <= '0;
                  wr_count    <= '0;
                  same_cnt    <= '0;
                  pc_valid    <= 1'b0;
                  halted      <= 1'b0;
                  watch_hit   <= 1'b0;
                  watch_data  <= '0;
                  hold_cnt    <= '0;
               end
            end

            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl with the default parameters (RESET_CYCLES=2,
// MAX_CYCLES=130, HALT_WINDOW=4, DUMP_CYCLES=2, WATCH_ADDR=8).
// Inputs are driven and outputs are sampled 1 time unit after each rising clock edge.
module tb_proc_run_ctrl;

   localparam int N = 64;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] pc;
   logic         we;
   logic [N-1:0] addr;
   logic [N-1:0] wdata;
   logic         proc_reset;
   logic         dump;
   logic         done;
   logic         halted;
   logic [31:0]  cycle_count;
   logic [15:0]  wr_count;
   logic         watch_hit;
   logic [N-1:0] watch_data;

   int checks = 0;
   int errors = 0;

   proc_run_ctrl dut (
      .CLOCK_50       (clk),
      .reset          (rst_n),
      .start          (start),
      .pc             (pc),
      .DM_writeEnable (we),
      .DM_addr        (addr),
      .DM_writeData   (wdata),
      .proc_reset     (proc_reset),
      .dump           (dump),
      .done           (done),
      .halted         (halted),
      .cycle_count    (cycle_count),
      .wr_count       (wr_count),
      .watch_hit      (watch_hit),
      .watch_data     (watch_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      pc    = '0;
      we    = 1'b0;
      addr  = '0;
      wdata = '0;

      // ---- 1: reset, then proc_reset for exactly two cycles
      repeat (3) tick();
      chk("rst_proc_reset", proc_reset, 1);
      chk("rst_dump", dump, 0);
      chk("rst_done", done, 0);
      chk("rst_halted", halted, 0);
      chk("rst_cycle_count", cycle_count, 0);
      chk("rst_watch_data", watch_data, 0);
      rst_n = 1'b1;
      chk("hold1_proc_reset", proc_reset, 1);
      tick();
      chk("hold2_proc_reset", proc_reset, 1);
      tick();
      chk("run0_proc_reset", proc_reset, 0);
      chk("run0_cycle_count", cycle_count, 0);
      chk("run0_dump", dump, 0);
      chk("run0_done", done, 0);

      // ---- 2 + 4: PC ramps 0..0x40 then sticks; three DM writes in RUN
      for (int i = 0; i <= 16; i++) begin
         pc = 64'(4 * i);
         we = 1'b0;
         case (i)
            1: begin we = 1'b1; addr = 64'h0;  wdata = 64'h1;    end
            2: begin we = 1'b1; addr = 64'h8;  wdata = 64'hDEAD; end
            3: begin we = 1'b1; addr = 64'h10; wdata = 64'h2;    end
            default: ;
         endcase
         tick();
      end
      we = 1'b0;
      pc = 64'h40;
      repeat (3) tick();
      chk("halt_rep3_dump", dump, 0);
      tick();
      chk("halt_dump1", dump, 1);
      chk("halt_dump1_proc_reset", proc_reset, 0);
      chk("halt_cycle_count", cycle_count, 21);
      chk("halt_wr_count", wr_count, 3);
      // A write issued during DUMP must be ignored.
      we = 1'b1; addr = 64'h8; wdata = 64'hBEEF;
      tick();
      chk("halt_dump2", dump, 1);
      chk("halt_dump2_done", done, 0);
      tick();
      we = 1'b0;
      chk("halt_done", done, 1);
      chk("halt_done_dump", dump, 0);
      chk("halt_halted", halted, 1);
      chk("halt_done_proc_reset", proc_reset, 1);
      chk("stats_wr_count", wr_count, 3);
      chk("stats_watch_hit", watch_hit, 1);
      chk("stats_watch_data", watch_data, 64'hDEAD);
      tick();
      chk("done_held", done, 1);
      chk("done_cycle_held", cycle_count, 21);

      // ---- 5: rerun from DONE clears the statistics and holds the core for two cycles
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rerun_hold1_proc_reset", proc_reset, 1);
      chk("rerun_done", done, 0);
      chk("rerun_cycle_count", cycle_count, 0);
      chk("rerun_wr_count", wr_count, 0);
      chk("rerun_watch_hit", watch_hit, 0);
      chk("rerun_watch_data", watch_data, 0);
      chk("rerun_halted", halted, 0);
      tick();
      chk("rerun_hold2_proc_reset", proc_reset, 1);
      tick();
      chk("rerun_run_proc_reset", proc_reset, 0);

      // ---- 3: PC always moving -> timeout; start pulse in RUN has no effect
      for (int k = 0; k <= 128; k++) begin
         pc    = 64'h1000 + 64'(4 * k);
         start = (k == 5);
         tick();
         if (k == 5) begin
            chk("run_start_ignored_done", done, 0);
            chk("run_start_ignored_proc_reset", proc_reset, 0);
            chk("run_start_ignored_count", cycle_count, 6);
         end
      end
      start = 1'b0;
      chk("to_pre_dump", dump, 0);
      chk("to_pre_count", cycle_count, 129);
      pc = 64'h1000 + 64'(4 * 129);
      tick();
      chk("to_dump", dump, 1);
      chk("to_dump_count", cycle_count, 130);
      chk("to_dump_proc_reset", proc_reset, 0);
      tick();
      chk("to_dump2", dump, 1);
      tick();
      chk("to_done", done, 1);
      chk("to_halted", halted, 0);
      chk("to_done_dump", dump, 0);
      tick();
      chk("to_count_frozen", cycle_count, 130);

      // ---- 6: async reset in the middle of a RUN
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         pc = 64'h2000 + 64'(4 * k);
         we = 1'b1; addr = 64'h8; wdata = 64'h100 + 64'(k);
         tick();
      end
      we = 1'b0;
      chk("mid_cycle_count", cycle_count, 5);
      chk("mid_wr_count", wr_count, 5);
      chk("mid_watch_hit", watch_hit, 1);
      chk("mid_watch_data", watch_data, 64'h104);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_proc_reset", proc_reset, 1);
      chk("async_dump", dump, 0);
      chk("async_done", done, 0);
      chk("async_cycle_count", cycle_count, 0);
      chk("async_wr_count", wr_count, 0);
      chk("async_watch_hit", watch_hit, 0);
      chk("async_watch_data", watch_data, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_hold2", proc_reset, 1);
      tick();
      chk("post_rst_run", proc_reset, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
